// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder.
//   GP_GROUP  - bits per generate/propagate group
//   chunk_ok  - legal WIDTH/STAGES combination (each chunk a whole number of groups)
//   grp_gen   - group generate from per-bit g/p
//   grp_prop  - group propagate from per-bit p
package cla_pkg;

  localparam int GP_GROUP = 4;

  function automatic bit chunk_ok(input int width, input int stages);
    return (stages > 0) && (width > 0) && ((width % (GP_GROUP * stages)) == 0);
  endfunction

  // Folded from the LSB upward; flattens to g3 | p3g2 | p3p2g1 | p3p2p1g0.
  function automatic logic grp_gen(input logic [GP_GROUP-1:0] g,
                                   input logic [GP_GROUP-1:0] p);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < GP_GROUP; i++) acc = g[i] | (p[i] & acc);
    return acc;
  endfunction

  function automatic logic grp_prop(input logic [GP_GROUP-1:0] p);
    return &p;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// cla_chunk: combinational CHUNK-bit carry-lookahead unit.
//   a, b  - chunk operands (b already inverted for subtract)
//   cin   - carry into the chunk LSB
//   sum   - chunk sum
//   cout  - carry out of the chunk MSB
//   cmsb  - carry into the chunk MSB (signed overflow = cmsb ^ cout)
module cla_chunk
  import cla_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  localparam int NG = CHUNK / GP_GROUP;

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] c;
  logic [NG:0]      gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group carries come from group g/p only; bit carries are resolved
  // inside each 4-bit group from that group's carry-in.
  always_comb begin
    gc    = '0;
    c     = '0;
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gc[j+1] = grp_gen(g[j*GP_GROUP +: GP_GROUP], p[j*GP_GROUP +: GP_GROUP])
              | (grp_prop(p[j*GP_GROUP +: GP_GROUP]) & gc[j]);
      c[j*GP_GROUP] = gc[j];
      for (int i = 1; i < GP_GROUP; i++) begin
        c[j*GP_GROUP+i] = g[j*GP_GROUP+i-1] | (p[j*GP_GROUP+i-1] & c[j*GP_GROUP+i-1]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NG];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one chunk per stage.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake
//   in_a, in_b            - operands
//   in_cin                - carry-in (ignored when in_sub=1)
//   in_sub                - 0: a+b+cin, 1: a-b
//   out_valid / out_ready - result handshake
//   out_sum, out_cout     - result mod 2^WIDTH and carry out (1 = no borrow on subtract)
//   out_ovf               - signed overflow
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!chunk_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH=%0d must be a multiple of %0d*STAGES (STAGES=%0d)",
           WIDTH, GP_GROUP, STAGES);
  end

  // Stage registers. a_r/b_r hold the not-yet-consumed operand chunks,
  // shifted down so the next stage always reads its chunk at bit 0.
  // sum_r accumulates finished chunks in place.
  logic             v_r   [STAGES];
  logic             c_r   [STAGES];
  logic [WIDTH-1:0] sum_r [STAGES];
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic             ovf_r;

  // Stage inputs: ports for stage 0, previous stage registers otherwise.
  logic             v_s   [STAGES];
  logic             c_s   [STAGES];
  logic [WIDTH-1:0] sum_s [STAGES];
  logic [WIDTH-1:0] a_s   [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];

  logic [CHUNK-1:0] sum_w  [STAGES];
  logic             cout_w [STAGES];
  logic             cmsb_w [STAGES];

  logic adv;

  // Global stall: the whole pipe moves together or not at all.
  assign adv      = !v_r[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_s[0]   = in_valid;
      assign a_s[0]   = in_a;
      assign b_s[0]   = in_sub ? ~in_b : in_b;
      assign c_s[0]   = in_sub | in_cin;
      assign sum_s[0] = '0;
    end else begin : g_link
      assign v_s[k]   = v_r[k-1];
      assign a_s[k]   = a_r[k-1];
      assign b_s[k]   = b_r[k-1];
      assign c_s[k]   = c_r[k-1];
      assign sum_s[k] = sum_r[k-1];
    end

    cla_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a    (a_s[k][CHUNK-1:0]),
      .b    (b_s[k][CHUNK-1:0]),
      .cin  (c_s[k]),
      .sum  (sum_w[k]),
      .cout (cout_w[k]),
      .cmsb (cmsb_w[k])
    );
  end

  // Bubbles load zeros so idle stages hold deterministic data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= 1'b0;
        c_r[k]   <= 1'b0;
        sum_r[k] <= '0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
      end
      ovf_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= v_s[k];
        c_r[k]   <= v_s[k] & cout_w[k];
        sum_r[k] <= v_s[k] ? (sum_s[k] | (WIDTH'(sum_w[k]) << (k * CHUNK))) : '0;
        a_r[k]   <= v_s[k] ? (a_s[k] >> CHUNK) : '0;
        b_r[k]   <= v_s[k] ? (b_s[k] >> CHUNK) : '0;
      end
      ovf_r <= v_s[STAGES-1] & (cout_w[STAGES-1] ^ cmsb_w[STAGES-1]);
    end
  end

  assign out_valid = v_r[STAGES-1];
  assign out_sum   = sum_r[STAGES-1];
  assign out_cout  = c_r[STAGES-1];
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for cla_pipe_adder.
//   dut16: WIDTH=16/STAGES=4, directed cases (latency, overflow, stream, stall, reset)
//   dut32: WIDTH=32/STAGES=4, random regression
//   dut8 : WIDTH=8/STAGES=1,  random regression
module tb_cla_pipe_adder;

  localparam int N_RND = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid_16 = 0, in_ready_16, in_cin_16 = 0, in_sub_16 = 0;
  logic [15:0] in_a_16 = '0, in_b_16 = '0, out_sum_16;
  logic        out_valid_16, out_ready_16 = 1, out_cout_16, out_ovf_16;

  logic        in_valid_32 = 0, in_ready_32, in_cin_32 = 0, in_sub_32 = 0;
  logic [31:0] in_a_32 = '0, in_b_32 = '0, out_sum_32;
  logic        out_valid_32, out_ready_32 = 1, out_cout_32, out_ovf_32;

  logic        in_valid_8 = 0, in_ready_8, in_cin_8 = 0, in_sub_8 = 0;
  logic [7:0]  in_a_8 = '0, in_b_8 = '0, out_sum_8;
  logic        out_valid_8, out_ready_8 = 1, out_cout_8, out_ovf_8;

  cla_pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .in_a(in_a_16), .in_b(in_b_16), .in_cin(in_cin_16), .in_sub(in_sub_16),
    .out_valid(out_valid_16), .out_ready(out_ready_16), .out_sum(out_sum_16),
    .out_cout(out_cout_16), .out_ovf(out_ovf_16));

  cla_pipe_adder #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .in_a(in_a_32), .in_b(in_b_32), .in_cin(in_cin_32), .in_sub(in_sub_32),
    .out_valid(out_valid_32), .out_ready(out_ready_32), .out_sum(out_sum_32),
    .out_cout(out_cout_32), .out_ovf(out_ovf_32));

  cla_pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in_a(in_a_8), .in_b(in_b_8), .in_cin(in_cin_8), .in_sub(in_sub_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .out_sum(out_sum_8),
    .out_cout(out_cout_8), .out_ovf(out_ovf_8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference result {ovf, cout, sum} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] mask, am, bm, s;
    logic [32:0] full;
    logic        cout, ovf;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am = a & mask;
    bm = b & mask;
    if (sub) begin
      s    = (am - bm) & mask;
      cout = (am >= bm);
      ovf  = (am[w-1] != bm[w-1]) && (s[w-1] != am[w-1]);
    end else begin
      full = {1'b0, am} + {1'b0, bm} + {32'd0, cin};
      s    = full[31:0] & mask;
      cout = full[w];
      ovf  = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    end
    return {ovf, cout, s};
  endfunction

  function automatic logic [31:0] rnd_op(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return mask;
      2:       return (mask >> 1) + 32'd1;
      3:       return mask >> 1;
      default: return $urandom() & mask;
    endcase
  endfunction

  // Scoreboards: push on input transfer, pop on output transfer.
  logic [33:0] q16[$], q32[$], q8[$];
  int          oc16[$];
  int          n_out16 = 0, n_out32 = 0, n_out8 = 0;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (out_valid_16 && out_ready_16) begin
        if (q16.size() == 0) chk("d16_spurious_output", 64'(1), 64'(0));
        else chk("d16_result", 64'({out_ovf_16, out_cout_16, 16'd0, out_sum_16}), 64'(q16.pop_front()));
        n_out16++;
        oc16.push_back(cyc);
      end
      if (in_valid_16 && in_ready_16)
        q16.push_back(model(16, 32'(in_a_16), 32'(in_b_16), in_cin_16, in_sub_16));
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (out_valid_32 && out_ready_32) begin
        if (q32.size() == 0) chk("d32_spurious_output", 64'(1), 64'(0));
        else chk("d32_result", 64'({out_ovf_32, out_cout_32, out_sum_32}), 64'(q32.pop_front()));
        n_out32++;
      end
      if (in_valid_32 && in_ready_32)
        q32.push_back(model(32, in_a_32, in_b_32, in_cin_32, in_sub_32));
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (out_valid_8 && out_ready_8) begin
        if (q8.size() == 0) chk("d8_spurious_output", 64'(1), 64'(0));
        else chk("d8_result", 64'({out_ovf_8, out_cout_8, 24'd0, out_sum_8}), 64'(q8.pop_front()));
        n_out8++;
      end
      if (in_valid_8 && in_ready_8)
        q8.push_back(model(8, 32'(in_a_8), 32'(in_b_8), in_cin_8, in_sub_8));
    end
  end

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int n;
    in_valid_16 = 1'b1;
    in_a_16 = a; in_b_16 = b; in_cin_16 = cin; in_sub_16 = sub;
    #1;
    n = 0;
    while (!in_ready_16 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("send16_ready_timeout", 64'(0), 64'(1));
    @(negedge clk);
  endtask

  task automatic single16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                          input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    send16(a, b, cin, sub);
    in_valid_16 = 1'b0;
    lat = 1;
    #1;
    while (!out_valid_16 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    chk("single_latency", 64'(lat), 64'(4));
    chk("single_sum", 64'(out_sum_16), 64'(exp_sum));
    chk("single_cout", 64'(out_cout_16), 64'(exp_cout));
    chk("single_ovf", 64'(out_ovf_16), 64'(exp_ovf));
    @(negedge clk);
  endtask

  logic [15:0] st_a   [8] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8000, 16'h00F0, 16'h7FFF, 16'hAAAA, 16'h0F0F};
  logic [15:0] st_b   [8] = '{16'h0002, 16'h0000, 16'h4321, 16'h8000, 16'h0010, 16'h0001, 16'h5555, 16'hF0F1};
  logic        st_cin [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        st_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int          base, n, sent32, sent8;
    logic        taken32, taken8;
    logic [17:0] snap;

    // Reset: held over two edges, outputs checked after the first.
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(out_valid_16), 64'(0));
    chk("rst_out_sum", 64'(out_sum_16), 64'(0));
    chk("rst_out_cout", 64'(out_cout_16), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf_16), 64'(0));
    chk("rst_in_ready", 64'(in_ready_16), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready_16), 64'(1));
    @(negedge clk);

    single16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    single16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Back-to-back stream of 8, including the full carry chain FFFF+0+1.
    oc16.delete();
    base = n_out16;
    for (int i = 0; i < 8; i++) send16(st_a[i], st_b[i], st_cin[i], st_sub[i]);
    in_valid_16 = 1'b0;
    repeat (8) @(negedge clk);
    chk("stream_count", 64'(n_out16 - base), 64'(8));
    if (oc16.size() == 8) chk("stream_contiguous", 64'(oc16[7] - oc16[0]), 64'(7));
    else chk("stream_out_cycles", 64'(oc16.size()), 64'(8));
    chk("stream_sb_empty", 64'(q16.size()), 64'(0));

    // Backpressure: stall 3 cycles with a result waiting and a new operand offered.
    base = n_out16;
    for (int i = 0; i < 5; i++) send16(16'h1000 * 16'(i) + 16'h0FFF, 16'h0001, 1'b0, 1'b0);
    in_valid_16 = 1'b1;
    in_a_16 = 16'h8001; in_b_16 = 16'h8001; in_cin_16 = 1'b1; in_sub_16 = 1'b0;
    out_ready_16 = 1'b0;
    #1;
    chk("bp_out_valid", 64'(out_valid_16), 64'(1));
    snap = {out_ovf_16, out_cout_16, out_sum_16};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("bp_in_ready", 64'(in_ready_16), 64'(0));
      chk("bp_valid_held", 64'(out_valid_16), 64'(1));
      chk("bp_outputs_stable", 64'({out_ovf_16, out_cout_16, out_sum_16}), 64'(snap));
    end
    out_ready_16 = 1'b1;
    @(negedge clk);
    in_valid_16 = 1'b0;
    n = 0;
    while (q16.size() != 0 && n < 30) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk("bp_sb_empty", 64'(q16.size()), 64'(0));
    chk("bp_count", 64'(n_out16 - base), 64'(6));

    // Reset with three transactions in flight.
    base = n_out16;
    for (int i = 0; i < 3; i++) send16(16'h0101 * 16'(i + 1), 16'h1111, 1'b0, 1'b0);
    in_valid_16 = 1'b0;
    rst = 1'b1;
    q16.delete();
    @(negedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid_16), 64'(0));
    chk("midrst_out_sum", 64'(out_sum_16), 64'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale_output", 64'(n_out16 - base), 64'(0));
    single16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Random regression on the 32/4 and 8/1 instances, run side by side.
    base = n_out32;
    n = n_out8;
    sent32 = 0; sent8 = 0; taken32 = 1'b0; taken8 = 1'b0;
    for (int c = 0; c < 80000 && (sent32 < N_RND || sent8 < N_RND); c++) begin
      @(negedge clk);
      if (!in_valid_32 || taken32) begin
        in_valid_32 = (sent32 < N_RND) && ($urandom_range(0, 3) != 0);
        in_a_32 = rnd_op(32); in_b_32 = rnd_op(32);
        in_cin_32 = 1'($urandom_range(0, 1)); in_sub_32 = 1'($urandom_range(0, 1));
      end
      if (!in_valid_8 || taken8) begin
        in_valid_8 = (sent8 < N_RND) && ($urandom_range(0, 3) != 0);
        in_a_8 = 8'(rnd_op(8)); in_b_8 = 8'(rnd_op(8));
        in_cin_8 = 1'($urandom_range(0, 1)); in_sub_8 = 1'($urandom_range(0, 1));
      end
      out_ready_32 = ($urandom_range(0, 3) != 0);
      out_ready_8  = ($urandom_range(0, 3) != 0);
      #1;
      taken32 = in_valid_32 && in_ready_32;
      taken8  = in_valid_8 && in_ready_8;
      if (taken32) sent32++;
      if (taken8) sent8++;
    end
    @(negedge clk);
    in_valid_32 = 1'b0; in_valid_8 = 1'b0;
    out_ready_32 = 1'b1; out_ready_8 = 1'b1;
    repeat (10) @(negedge clk);
    chk("rnd32_sent", 64'(sent32), 64'(N_RND));
    chk("rnd32_received", 64'(n_out32 - base), 64'(N_RND));
    chk("rnd32_sb_empty", 64'(q32.size()), 64'(0));
    chk("rnd8_sent", 64'(sent8), 64'(N_RND));
    chk("rnd8_received", 64'(n_out8 - n), 64'(N_RND));
    chk("rnd8_sb_empty", 64'(q8.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
